// File: rtl/ad_jesd204_rx_deframer_pkg.sv
// Shared definitions for the JESD204 RX deframer: alignment FSM encoding,
// sample geometry derivation and SOF decoding helpers.
package ad_jesd204_rx_deframer_pkg;

  typedef enum logic {
    ST_HUNT = 1'b0,
    ST_LOCK = 1'b1
  } align_state_e;

  // Octets per converter sample: wide converters need two octets.
  function automatic int oct_per_sample(input int channel_width);
    return (channel_width > 8) ? 2 : 1;
  endfunction

  // Samples per channel carried in one beat across all lanes.
  function automatic int data_path_width(input int num_lanes, input int ops,
                                         input int num_channels);
    return (num_lanes * 4) / (ops * num_channels);
  endfunction

  // Octet position of the lowest set SOF bit.
  function automatic logic [1:0] sof_to_offset(input logic [3:0] sof);
    logic [1:0] off;
    if (sof[0]) begin
      off = 2'd0;
    end else if (sof[1]) begin
      off = 2'd1;
    end else if (sof[2]) begin
      off = 2'd2;
    end else if (sof[3]) begin
      off = 2'd3;
    end else begin
      off = 2'd0;
    end
    return off;
  endfunction

  // True when exactly one SOF bit is set.
  function automatic logic sof_is_onehot(input logic [3:0] sof);
    return (sof != 4'd0) && ((sof & (sof - 4'd1)) == 4'd0);
  endfunction

endpackage

// File: rtl/ad_jesd204_rx_lane_align.sv
// Per-lane octet realignment: keeps the previous beat and selects the
// 32-bit window starting at the locked SOF octet offset.
module ad_jesd204_rx_lane_align (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        valid_i,
  input  logic [1:0]  offset_i,
  input  logic [31:0] data_i,
  output logic [31:0] aligned_o
);

  logic [31:0] prev_q;
  logic [31:0] aligned_q;
  logic [31:0] aligned_d;
  logic [63:0] window_s;

  // Offset mux over the {current, previous} beat window.
  always_comb begin
    window_s  = {data_i, prev_q};
    aligned_d = window_s[{offset_i, 3'b000} +: 32];
  end

  // History and aligned-word registers advance only on valid beats.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prev_q    <= 32'd0;
      aligned_q <= 32'd0;
    end else if (valid_i) begin
      prev_q    <= data_i;
      aligned_q <= aligned_d;
    end
  end

  assign aligned_o = aligned_q;

endmodule

// File: rtl/ad_jesd204_rx_deframer.sv
// JESD204 RX transport-layer deframer: SOF alignment FSM, octet-to-sample
// mapping with format conversion, and an output FIFO toward the ADC sink.
module ad_jesd204_rx_deframer
  import ad_jesd204_rx_deframer_pkg::*;
#(
  parameter int NUM_LANES     = 2,
  parameter int NUM_CHANNELS  = 2,
  parameter int CHANNEL_WIDTH = 14,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                      rx_clk,
  input  logic                      rx_rstn,
  input  logic [3:0]                rx_sof,
  input  logic                      rx_valid,
  input  logic [NUM_LANES*32-1:0]   rx_data,
  output logic                      rx_ready,
  input  logic [NUM_CHANNELS-1:0]   cfg_enable,
  input  logic                      cfg_offset_bin,
  output logic                      adc_valid,
  output logic [NUM_LANES*32-1:0]   adc_data,
  input  logic                      adc_ready,
  output logic                      status_locked,
  output logic                      status_align_err,
  output logic                      status_ovf,
  output logic [15:0]               status_ovf_count,
  input  logic                      status_clr
);

  localparam int OPS         = oct_per_sample(CHANNEL_WIDTH);
  localparam int SW          = 8 * OPS;
  localparam int DPW         = data_path_width(NUM_LANES, OPS, NUM_CHANNELS);
  localparam int DW          = NUM_LANES * 32;
  localparam int NUM_SAMPLES = DW / SW;
  localparam int AW          = $clog2(FIFO_DEPTH);

  align_state_e state_q, state_d;
  logic [1:0]   offset_q, offset_d;
  logic [1:0]   sof_off_s;
  logic         sof_hit_s, sof_mismatch_s;
  logic         locked_s, beat_push_s, err_set_s;

  logic [DW-1:0] aligned_s;
  logic          align_vld_q;
  logic [DW-1:0] fmt_d, fmt_q;
  logic          fmt_vld_q;

  logic [DW-1:0] mem_q [FIFO_DEPTH];
  logic [AW:0]   wr_ptr_q, rd_ptr_q;
  logic          empty_s, full_s, push_s, pop_s, drop_s;

  logic          align_err_q, ovf_q;
  logic [15:0]   ovf_count_q;

  // SOF decode shared by the next-state and output logic.
  always_comb begin
    sof_off_s      = sof_to_offset(rx_sof);
    sof_hit_s      = rx_valid & (|rx_sof);
    sof_mismatch_s = sof_hit_s & (~sof_is_onehot(rx_sof) | (sof_off_s != offset_q));
  end

  // Alignment FSM state and locked offset.
  always_ff @(posedge rx_clk or negedge rx_rstn) begin
    if (!rx_rstn) begin
      state_q  <= ST_HUNT;
      offset_q <= 2'd0;
    end else begin
      state_q  <= state_d;
      offset_q <= offset_d;
    end
  end

  // Next state: lock on any SOF while hunting, fall back on a SOF move.
  always_comb begin
    state_d  = state_q;
    offset_d = offset_q;
    case (state_q)
      ST_HUNT: begin
        if (sof_hit_s) begin
          state_d  = ST_LOCK;
          offset_d = sof_off_s;
        end else begin
          state_d  = ST_HUNT;
        end
      end
      ST_LOCK: begin
        if (sof_mismatch_s) begin
          state_d = ST_HUNT;
        end else begin
          state_d = ST_LOCK;
        end
      end
      default: begin
        state_d  = ST_HUNT;
        offset_d = 2'd0;
      end
    endcase
  end

  // FSM outputs: forward beats only while locked and consistent.
  always_comb begin
    locked_s    = 1'b0;
    beat_push_s = 1'b0;
    err_set_s   = 1'b0;
    case (state_q)
      ST_HUNT: begin
        locked_s = 1'b0;
      end
      ST_LOCK: begin
        locked_s    = 1'b1;
        beat_push_s = rx_valid & ~sof_mismatch_s;
        err_set_s   = sof_mismatch_s;
      end
      default: begin
        locked_s = 1'b0;
      end
    endcase
  end

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    ad_jesd204_rx_lane_align u_lane_align (
      .clk_i     (rx_clk),
      .rst_ni    (rx_rstn),
      .valid_i   (rx_valid),
      .offset_i  (offset_q),
      .data_i    (rx_data[32*l +: 32]),
      .aligned_o (aligned_s[32*l +: 32])
    );
  end

  // Sample k takes OPS consecutive octets, first octet in the MSBs; its output
  // slot k is already channel-major because channel = k / DPW.
  for (genvar k = 0; k < NUM_SAMPLES; k++) begin : g_sample
    logic [SW-1:0]                   raw_s;
    logic signed [CHANNEL_WIDTH-1:0] top_s;
    for (genvar o = 0; o < OPS; o++) begin : g_oct
      assign raw_s[SW-1-8*o -: 8] = aligned_s[8*(k*OPS+o) +: 8];
    end
    assign top_s = {raw_s[SW-1] ^ cfg_offset_bin, raw_s[SW-2 -: CHANNEL_WIDTH-1]};
    assign fmt_d[k*SW +: SW] = cfg_enable[k/DPW] ? SW'(top_s) : {SW{1'b0}};
  end

  // Align and format pipeline valid flags plus the formatted beat.
  always_ff @(posedge rx_clk or negedge rx_rstn) begin
    if (!rx_rstn) begin
      align_vld_q <= 1'b0;
      fmt_vld_q   <= 1'b0;
      fmt_q       <= {DW{1'b0}};
    end else begin
      align_vld_q <= beat_push_s;
      fmt_vld_q   <= align_vld_q;
      fmt_q       <= fmt_d;
    end
  end

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  always_comb begin
    empty_s = (wr_ptr_q == rd_ptr_q);
    full_s  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    pop_s   = ~empty_s & adc_ready;
    push_s  = fmt_vld_q & (~full_s | pop_s);
    drop_s  = fmt_vld_q & full_s & ~pop_s;
  end

  // FIFO storage and pointers; reset discards all contents.
  always_ff @(posedge rx_clk or negedge rx_rstn) begin
    if (!rx_rstn) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= {DW{1'b0}};
      end
      wr_ptr_q <= {(AW+1){1'b0}};
      rd_ptr_q <= {(AW+1){1'b0}};
    end else begin
      if (push_s) begin
        mem_q[wr_ptr_q[AW-1:0]] <= fmt_q;
        wr_ptr_q <= wr_ptr_q + {{AW{1'b0}}, 1'b1};
      end
      if (pop_s) begin
        rd_ptr_q <= rd_ptr_q + {{AW{1'b0}}, 1'b1};
      end
    end
  end

  // Sticky status; a new event in the clear cycle takes precedence.
  always_ff @(posedge rx_clk or negedge rx_rstn) begin
    if (!rx_rstn) begin
      align_err_q <= 1'b0;
      ovf_q       <= 1'b0;
      ovf_count_q <= 16'd0;
    end else begin
      if (err_set_s) begin
        align_err_q <= 1'b1;
      end else if (status_clr) begin
        align_err_q <= 1'b0;
      end
      if (drop_s) begin
        ovf_q <= 1'b1;
        if (status_clr) begin
          ovf_count_q <= 16'd1;
        end else if (ovf_count_q != 16'hFFFF) begin
          ovf_count_q <= ovf_count_q + 16'd1;
        end
      end else if (status_clr) begin
        ovf_q       <= 1'b0;
        ovf_count_q <= 16'd0;
      end
    end
  end

  assign rx_ready         = 1'b1;
  assign adc_valid        = ~empty_s;
  assign adc_data         = mem_q[rd_ptr_q[AW-1:0]];
  assign status_locked    = locked_s;
  assign status_align_err = align_err_q;
  assign status_ovf       = ovf_q;
  assign status_ovf_count = ovf_count_q;

endmodule

// File: tb/tb_ad_jesd204_rx_deframer.sv
// Directed bench for ad_jesd204_rx_deframer (2 lanes, 2 channels, 14-bit).
module tb_ad_jesd204_rx_deframer;

  logic        rx_clk = 1'b0;
  logic        rx_rstn;
  logic [3:0]  rx_sof;
  logic        rx_valid;
  logic [63:0] rx_data;
  logic        rx_ready;
  logic [1:0]  cfg_enable;
  logic        cfg_offset_bin;
  logic        adc_valid;
  logic [63:0] adc_data;
  logic        adc_ready;
  logic        status_locked;
  logic        status_align_err;
  logic        status_ovf;
  logic [15:0] status_ovf_count;
  logic        status_clr;

  int pass_cnt  = 0;
  int total_cnt = 0;

  typedef struct {
    logic [31:0] l0;
    logic [31:0] l1;
    logic [1:0]  en;
    logic        ob;
    logic [63:0] exp;
  } vec_t;

  vec_t tbl [6];

  always #5 rx_clk = ~rx_clk;

  ad_jesd204_rx_deframer #(
    .NUM_LANES(2), .NUM_CHANNELS(2), .CHANNEL_WIDTH(14), .FIFO_DEPTH(4)
  ) dut (
    .rx_clk(rx_clk), .rx_rstn(rx_rstn), .rx_sof(rx_sof), .rx_valid(rx_valid),
    .rx_data(rx_data), .rx_ready(rx_ready), .cfg_enable(cfg_enable),
    .cfg_offset_bin(cfg_offset_bin), .adc_valid(adc_valid), .adc_data(adc_data),
    .adc_ready(adc_ready), .status_locked(status_locked),
    .status_align_err(status_align_err), .status_ovf(status_ovf),
    .status_ovf_count(status_ovf_count), .status_clr(status_clr)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: actual %h required %h", name, act, exp);
  endtask

  task automatic drive(input logic v, input logic [3:0] sof, input logic [31:0] l0,
                       input logic [31:0] l1);
    rx_valid = v;
    rx_sof   = sof;
    rx_data  = {l1, l0};
    @(posedge rx_clk);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 4'b0000, 32'd0, 32'd0);
  endtask

  // Reference: octet pairs MSB-first, optional MSB flip, keep top 14 bits sign-extended.
  function automatic logic [63:0] model(input logic [31:0] l0, input logic [31:0] l1,
                                        input logic [1:0] en, input logic ob);
    logic [63:0]        r;
    logic [31:0]        w;
    logic [15:0]        raw;
    logic signed [15:0] sv;
    r = 64'd0;
    for (int k = 0; k < 4; k++) begin
      w   = (k < 2) ? l0 : l1;
      raw = {w[16*(k%2) +: 8], w[16*(k%2)+8 +: 8]};
      if (ob) raw = raw ^ 16'h8000;
      sv = $signed(raw) >>> 2;
      if (en[k/2]) r[16*k +: 16] = sv;
    end
    return r;
  endfunction

  function automatic logic [31:0] ramp(input int n, input int lane);
    logic [7:0] b;
    b = 8'(8 * n + 4 * lane);
    return {b + 8'd3, b + 8'd2, b + 8'd1, b};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "timeout");
  end

  initial begin
    int         pulses;
    logic [63:0] exp_q [4];
    int         c;

    tbl[0] = '{32'h0000_0080, 32'h0000_0080, 2'b11, 1'b1, 64'hE000_0000_E000_0000};
    tbl[1] = '{32'h0000_0080, 32'h0000_0080, 2'b10, 1'b1, 64'hE000_0000_0000_0000};
    tbl[2] = '{32'h0040_0010, 32'hFC00_0080, 2'b11, 1'b0, 64'h003F_E000_1000_0400};
    tbl[3] = '{32'h3412_CDAB, 32'hFFFF_FFFF, 2'b01, 1'b0, 64'h0000_0000_048D_EAF3};
    tbl[4] = '{32'h3412_CDAB, 32'hFFFF_FFFF, 2'b11, 1'b1, 64'h1FFF_1FFF_E48D_0AF3};
    tbl[5] = '{32'hFFFF_FFFF, 32'h0300_0300, 2'b11, 1'b0, 64'h0000_0000_FFFF_FFFF};

    rx_rstn = 1'b0; rx_sof = 4'd0; rx_valid = 1'b0; rx_data = 64'd0;
    cfg_enable = 2'b11; cfg_offset_bin = 1'b0; adc_ready = 1'b0; status_clr = 1'b0;
    #12;
    check("rst_adc_valid", adc_valid, 0);
    check("rst_adc_data", adc_data, 0);
    check("rst_rx_ready", rx_ready, 1);
    check("rst_locked", status_locked, 0);
    check("rst_err", status_align_err, 0);
    check("rst_ovf", status_ovf, 0);
    check("rst_count", status_ovf_count, 0);
    rx_rstn = 1'b1;
    @(posedge rx_clk); #1;
    adc_ready = 1'b1;

    // Ramp with SOF at octet 0 every 4 beats; beat n appears after edge n+3.
    for (int j = 0; j < 15; j++) begin
      if (j < 12) drive(1'b1, (j % 4 == 0) ? 4'b0001 : 4'b0000, ramp(j, 0), ramp(j, 1));
      else idle();
      if (j == 0) check("t1_locked", status_locked, 1);
      if (j == 2) check("t1_latency", adc_valid, 0);
      if (j >= 3 && j <= 13) begin
        check("t1_valid", adc_valid, 1);
        check("t1_data", adc_data, model(ramp(j-3, 0), ramp(j-3, 1), 2'b11, 1'b0));
      end
      if (j == 14) check("t1_drained", adc_valid, 0);
    end
    check("t1_ovf", status_ovf, 0);
    check("t1_err", status_align_err, 0);

    // SOF moves while locked: error, relock, mismatching beat never emitted.
    drive(1'b1, 4'b0010, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    check("t3_err", status_align_err, 1);
    check("t3_unlocked", status_locked, 0);
    drive(1'b1, 4'b0001, 32'h4433_2211, 32'h8877_6655);
    check("t3_relocked", status_locked, 1);
    drive(1'b1, 4'b0000, 32'h0C0B_0A09, 32'h100F_0E0D);
    pulses = 0;
    for (int j = 0; j < 6; j++) begin
      idle();
      if (adc_valid) begin
        pulses++;
        check("t3_data", adc_data, model(32'h4433_2211, 32'h8877_6655, 2'b11, 1'b0));
      end
    end
    check("t3_pulses", 64'(pulses), 1);

    // Sink stalled for FIFO_DEPTH+5 pushes: 5 drops, head order preserved.
    adc_ready = 1'b0;
    for (int i = 1; i <= 9; i++) drive(1'b1, 4'b0000, ramp(40+i, 0), ramp(40+i, 1));
    idle(); idle(); idle();
    check("t4_ovf", status_ovf, 1);
    check("t4_count", status_ovf_count, 5);
    exp_q[0] = model(32'h0C0B_0A09, 32'h100F_0E0D, 2'b11, 1'b0);
    for (int i = 1; i < 4; i++) exp_q[i] = model(ramp(40+i, 0), ramp(40+i, 1), 2'b11, 1'b0);
    adc_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("t4_head_valid", adc_valid, 1);
      check("t4_head_data", adc_data, exp_q[i]);
      idle();
    end
    check("t4_empty", adc_valid, 0);
    status_clr = 1'b1; idle(); status_clr = 1'b0;
    check("t4_clr_ovf", status_ovf, 0);
    check("t4_clr_count", status_ovf_count, 0);
    check("t4_clr_err", status_align_err, 0);

    // Same stall with the clear landing on the final drop.
    adc_ready = 1'b0;
    for (int i = 1; i <= 9; i++) drive(1'b1, 4'b0000, ramp(60+i, 0), ramp(60+i, 1));
    idle();
    check("t4b_count_pre", status_ovf_count, 4);
    status_clr = 1'b1; idle(); status_clr = 1'b0;
    check("t4b_count", status_ovf_count, 1);
    check("t4b_ovf", status_ovf, 1);
    adc_ready = 1'b1;
    for (int i = 0; i < 5; i++) idle();
    check("t4b_drained", adc_valid, 0);

    // Reset with three entries queued.
    adc_ready = 1'b0;
    for (int i = 1; i <= 3; i++) drive(1'b1, 4'b0000, ramp(80+i, 0), ramp(80+i, 1));
    idle(); idle();
    check("t6_pre_valid", adc_valid, 1);
    check("t6_pre_locked", status_locked, 1);
    #2 rx_rstn = 1'b0;
    #1;
    check("t6_valid", adc_valid, 0);
    check("t6_data", adc_data, 0);
    check("t6_locked", status_locked, 0);
    check("t6_ovf", status_ovf, 0);
    check("t6_count", status_ovf_count, 0);
    check("t6_err", status_align_err, 0);
    @(negedge rx_clk); rx_rstn = 1'b1;
    @(posedge rx_clk); #1;
    idle(); idle();
    check("t6_post_valid", adc_valid, 0);
    check("t6_post_locked", status_locked, 0);

    // SOF at octet 2: lane0 window 32'h55443322.
    drive(1'b1, 4'b0100, 32'h3322_1100, 32'hBBAA_9988);
    check("t2_locked", status_locked, 1);
    drive(1'b1, 4'b0000, 32'h7766_5544, 32'hFFEE_DDCC);
    idle(); idle();
    check("t2_valid", adc_valid, 1);
    check("t2_data", adc_data, 64'hF337_EAAE_1115_088C);
    adc_ready = 1'b1;
    idle();

    // Relock at offset 0 for the format table.
    drive(1'b1, 4'b0001, 32'd0, 32'd0);
    check("tv_err", status_align_err, 1);
    drive(1'b1, 4'b0001, 32'd0, 32'd0);
    check("tv_locked", status_locked, 1);
    for (int j = 0; j < 9; j++) begin
      c = (j < 2) ? 0 : ((j - 2 > 5) ? 5 : j - 2);
      cfg_enable     = tbl[c].en;
      cfg_offset_bin = tbl[c].ob;
      if (j < 6) drive(1'b1, 4'b0000, tbl[j].l0, tbl[j].l1);
      else drive(1'b1, 4'b0000, 32'd0, 32'd0);
      if (j >= 3) begin
        check("tv_valid", adc_valid, 1);
        check("tv_data", adc_data, tbl[j-3].exp);
      end
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
